// File: rtl/timer_pkg.sv
// ---------------------------------------------------------------------------
// timer_pkg
// Shared definitions for the timer counter/compare stage.
//   timer_state_e        : FSM state encoding (IDLE / RUN / DONE)
//   TIMER_WIDTH_DEFAULT  : default counter/reload/compare width
// ---------------------------------------------------------------------------
package timer_pkg;

   localparam int unsigned TIMER_WIDTH_DEFAULT = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } timer_state_e;

endpackage : timer_pkg

// File: rtl/timer_cmp_pwm.sv
// ---------------------------------------------------------------------------
// timer_cmp_pwm
// Up-counter with auto-reload, compare event and PWM output, advanced by a
// one-cycle prescaler tick used as a clock enable in the clk_i domain.
//
// Ports:
//   clk_i      system clock
//   rst_ni     asynchronous active-low reset
//   tick_i     prescaled tick, advances the counter when high (with en_i)
//   en_i       global enable; low freezes counter/state, ticks dropped
//   start_i    pulse: (re)start counting from 0, load shadows
//   stop_i     pulse: abort to IDLE
//   oneshot_i  1 = go to DONE after the first overflow, 0 = periodic
//   reload_i   period minus one (top value)
//   compare_i  PWM duty / compare threshold
//   count_o    current counter value
//   pwm_o      high while count_o < active compare
//   ovf_o      one-cycle pulse on wrap top -> 0
//   cmp_o      one-cycle pulse when the counter becomes equal to compare
//   running_o  high in RUN
//   state_o    current FSM state (debug visibility)
//
// Handshake: there is no valid/ready pairing here; tick_i, start_i and
// stop_i are single-cycle qualifiers sampled on every rising clk_i edge,
// with priority stop_i > start_i > (tick_i & en_i).
// ---------------------------------------------------------------------------
module timer_cmp_pwm
   import timer_pkg::*;
#(
   parameter int unsigned WIDTH = TIMER_WIDTH_DEFAULT
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             tick_i,
   input  logic             en_i,
   input  logic             start_i,
   input  logic             stop_i,
   input  logic             oneshot_i,
   input  logic [WIDTH-1:0] reload_i,
   input  logic [WIDTH-1:0] compare_i,
   output logic [WIDTH-1:0] count_o,
   output logic             pwm_o,
   output logic             ovf_o,
   output logic             cmp_o,
   output logic             running_o,
   output timer_state_e     state_o
);

   timer_state_e     state_q, state_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic [WIDTH-1:0] reload_sh_q, reload_sh_d;
   logic [WIDTH-1:0] cmp_sh_q, cmp_sh_d;
   logic             pwm_q, pwm_d;
   logic             ovf_q, ovf_d;
   logic             cmp_q, cmp_d;

   logic             adv;
   logic             at_top;
   logic [WIDTH-1:0] count_inc;

   // A qualified tick only counts while running; ticks with en_i low are lost.
   assign adv       = tick_i & en_i & (state_q == RUN);
   assign at_top    = (count_q == reload_sh_q);
   assign count_inc = count_q + 1'b1;

   // -----------------------------------------------------------------------
   // State / datapath register
   // -----------------------------------------------------------------------
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= IDLE;
         count_q     <= '0;
         reload_sh_q <= '0;
         cmp_sh_q    <= '0;
         pwm_q       <= 1'b0;
         ovf_q       <= 1'b0;
         cmp_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         reload_sh_q <= reload_sh_d;
         cmp_sh_q    <= cmp_sh_d;
         pwm_q       <= pwm_d;
         ovf_q       <= ovf_d;
         cmp_q       <= cmp_d;
      end
   end

   // -----------------------------------------------------------------------
   // Next-state logic
   // -----------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      if (stop_i) begin
         state_d = IDLE;
      end else if (start_i && en_i) begin
         state_d = RUN;
      end else if (start_i) begin
         // start is honoured regardless of en_i
         state_d = RUN;
      end else if (adv && at_top && oneshot_i) begin
         state_d = DONE;
      end
   end

   // -----------------------------------------------------------------------
   // Next datapath and registered-output values
   // -----------------------------------------------------------------------
   always_comb begin
      count_d     = count_q;
      reload_sh_d = reload_sh_q;
      cmp_sh_d    = cmp_sh_q;
      pwm_d       = pwm_q;
      ovf_d       = 1'b0;
      cmp_d       = 1'b0;

      if (stop_i) begin
         count_d = '0;
         pwm_d   = 1'b0;
      end else if (start_i) begin
         // Restart: no event pulses, shadows take the live inputs.
         count_d     = '0;
         reload_sh_d = reload_i;
         cmp_sh_d    = compare_i;
         pwm_d       = (compare_i != '0);
      end else if (adv) begin
         if (at_top) begin
            // Wrap: the compare and PWM decisions for the new count use the
            // freshly loaded compare value, so the new period starts clean.
            count_d     = '0;
            ovf_d       = 1'b1;
            reload_sh_d = reload_i;
            cmp_sh_d    = compare_i;
            cmp_d       = (compare_i == '0);
            pwm_d       = oneshot_i ? 1'b0 : (compare_i != '0);
         end else begin
            count_d = count_inc;
            cmp_d   = (count_inc == cmp_sh_q);
            pwm_d   = (count_inc < cmp_sh_q);
         end
      end else if (state_q != RUN) begin
         count_d = '0;
         pwm_d   = 1'b0;
      end
   end

   // -----------------------------------------------------------------------
   // Outputs (all driven from registers)
   // -----------------------------------------------------------------------
   always_comb begin
      count_o   = count_q;
      pwm_o     = pwm_q;
      ovf_o     = ovf_q;
      cmp_o     = cmp_q;
      running_o = (state_q == RUN);
      state_o   = state_q;
   end

endmodule : timer_cmp_pwm

// File: tb/tb_timer_cmp_pwm.sv
// ---------------------------------------------------------------------------
// tb_timer_cmp_pwm
// Cycle-by-cycle vector table for timer_cmp_pwm (WIDTH=16) plus hand-written
// sequences for asynchronous reset mid-count and the all-ones wrap.
// ---------------------------------------------------------------------------
module tb_timer_cmp_pwm;
   import timer_pkg::*;

   localparam int W = 16;

   typedef struct {
      logic         tick;
      logic         en;
      logic         start;
      logic         stop;
      logic         oneshot;
      logic [W-1:0] reload;
      logic [W-1:0] compare;
      logic [W-1:0] e_count;
      logic         e_pwm;
      logic         e_ovf;
      logic         e_cmp;
      logic [1:0]   e_st;
   } vec_t;

   logic         clk_i = 1'b0;
   logic         rst_ni;
   logic         tick_i, en_i, start_i, stop_i, oneshot_i;
   logic [W-1:0] reload_i, compare_i;
   logic [W-1:0] count_o;
   logic         pwm_o, ovf_o, cmp_o, running_o;
   timer_state_e state_o;

   int total = 0;
   int bad   = 0;
   vec_t vec_q[$];

   localparam logic [1:0] S_I = 2'd0;
   localparam logic [1:0] S_R = 2'd1;
   localparam logic [1:0] S_D = 2'd2;

   timer_cmp_pwm #(.WIDTH(W)) dut (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .tick_i    (tick_i),
      .en_i      (en_i),
      .start_i   (start_i),
      .stop_i    (stop_i),
      .oneshot_i (oneshot_i),
      .reload_i  (reload_i),
      .compare_i (compare_i),
      .count_o   (count_o),
      .pwm_o     (pwm_o),
      .ovf_o     (ovf_o),
      .cmp_o     (cmp_o),
      .running_o (running_o),
      .state_o   (state_o)
   );

   // clock
   always #5 clk_i = ~clk_i;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic add_v(input logic t, input logic e, input logic s, input logic p,
                        input logic o, input logic [W-1:0] rel, input logic [W-1:0] cmp,
                        input logic [W-1:0] ec, input logic ep, input logic eo,
                        input logic ecm, input logic [1:0] est);
      vec_t v;
      v.tick = t; v.en = e; v.start = s; v.stop = p; v.oneshot = o;
      v.reload = rel; v.compare = cmp;
      v.e_count = ec; v.e_pwm = ep; v.e_ovf = eo; v.e_cmp = ecm; v.e_st = est;
      vec_q.push_back(v);
   endtask

   task automatic drive_idle();
      tick_i = 1'b0; en_i = 1'b1; start_i = 1'b0; stop_i = 1'b0;
   endtask

   task automatic check_all(input string tag, input logic [W-1:0] c, input logic p,
                            input logic o, input logic cm, input logic [1:0] st);
      check({tag, ".count"},   32'(count_o),   32'(c));
      check({tag, ".pwm"},     32'(pwm_o),     32'(p));
      check({tag, ".ovf"},     32'(ovf_o),     32'(o));
      check({tag, ".cmp"},     32'(cmp_o),     32'(cm));
      check({tag, ".running"}, 32'(running_o), 32'(st == S_R));
      check({tag, ".state"},   32'(state_o),   32'(st));
   endtask

   task automatic fill_table();
      // periodic PWM: reload=4, compare=2, tick every cycle
      add_v(0,1,1,0,0, 4,2, 0,1,0,0,S_R);
      add_v(1,1,0,0,0, 4,2, 1,1,0,0,S_R);
      add_v(1,1,0,0,0, 4,2, 2,0,0,1,S_R);
      add_v(1,1,0,0,0, 4,2, 3,0,0,0,S_R);
      add_v(1,1,0,0,0, 4,2, 4,0,0,0,S_R);
      add_v(1,1,0,0,0, 4,2, 0,1,1,0,S_R);
      add_v(1,1,0,0,0, 4,2, 1,1,0,0,S_R);
      add_v(0,1,0,1,0, 4,2, 0,0,0,0,S_I);
      add_v(1,1,0,0,0, 4,2, 0,0,0,0,S_I);
      // shadow update: reload=9, compare 3 -> 7 at count 5
      add_v(0,1,1,0,0, 9,3, 0,1,0,0,S_R);
      add_v(1,1,0,0,0, 9,3, 1,1,0,0,S_R);
      add_v(1,1,0,0,0, 9,3, 2,1,0,0,S_R);
      add_v(1,1,0,0,0, 9,3, 3,0,0,1,S_R);
      add_v(1,1,0,0,0, 9,3, 4,0,0,0,S_R);
      add_v(1,1,0,0,0, 9,3, 5,0,0,0,S_R);
      add_v(1,1,0,0,0, 9,7, 6,0,0,0,S_R);
      add_v(1,1,0,0,0, 9,7, 7,0,0,0,S_R);
      add_v(1,1,0,0,0, 9,7, 8,0,0,0,S_R);
      add_v(1,1,0,0,0, 9,7, 9,0,0,0,S_R);
      add_v(1,1,0,0,0, 9,7, 0,1,1,0,S_R);
      for (int k = 1; k <= 6; k++) add_v(1,1,0,0,0, 9,7, W'(k),1,0,0,S_R);
      add_v(1,1,0,0,0, 9,7, 7,0,0,1,S_R);
      add_v(0,1,0,1,0, 9,7, 0,0,0,0,S_I);
      // one-shot: reload=3, compare=2, tick every 4th cycle
      add_v(0,1,1,0,1, 3,2, 0,1,0,0,S_R);
      for (int k = 1; k <= 3; k++) begin
         for (int j = 0; j < 3; j++) add_v(0,1,0,0,1, 3,2, W'(k-1),(k-1) < 2,0,0,S_R);
         add_v(1,1,0,0,1, 3,2, W'(k),k < 2,0,k == 2,S_R);
      end
      for (int j = 0; j < 3; j++) add_v(0,1,0,0,1, 3,2, 3,0,0,0,S_R);
      add_v(1,1,0,0,1, 3,2, 0,0,1,0,S_D);
      for (int j = 0; j < 3; j++) add_v(0,1,0,0,1, 3,2, 0,0,0,0,S_D);
      add_v(1,1,0,0,1, 3,2, 0,0,0,0,S_D);
      add_v(0,1,1,0,0, 3,2, 0,1,0,0,S_R);
      add_v(1,1,0,0,0, 3,2, 1,1,0,0,S_R);
      // compare=0: pwm constant 0, cmp at each wrap (restart from count 1)
      add_v(0,1,1,0,0, 2,0, 0,0,0,0,S_R);
      add_v(1,1,0,0,0, 2,0, 1,0,0,0,S_R);
      add_v(1,1,0,0,0, 2,0, 2,0,0,0,S_R);
      add_v(1,1,0,0,0, 2,0, 0,0,1,1,S_R);
      add_v(1,1,0,0,0, 2,0, 1,0,0,0,S_R);
      // compare=reload+1: pwm constant 1, no cmp
      add_v(0,1,1,0,0, 2,3, 0,1,0,0,S_R);
      add_v(1,1,0,0,0, 2,3, 1,1,0,0,S_R);
      add_v(1,1,0,0,0, 2,3, 2,1,0,0,S_R);
      add_v(1,1,0,0,0, 2,3, 0,1,1,0,S_R);
      // reload=0: ovf on every qualified tick
      add_v(0,1,1,0,0, 0,1, 0,1,0,0,S_R);
      add_v(1,1,0,0,0, 0,1, 0,1,1,0,S_R);
      add_v(1,1,0,0,0, 0,1, 0,1,1,0,S_R);
      add_v(0,1,0,0,0, 0,1, 0,1,0,0,S_R);
      // control priority and enable
      add_v(0,1,1,0,0, 9,5, 0,1,0,0,S_R);
      add_v(1,1,0,0,0, 9,5, 1,1,0,0,S_R);
      add_v(1,1,0,0,0, 9,5, 2,1,0,0,S_R);
      add_v(1,1,1,1,0, 9,5, 0,0,0,0,S_I);
      add_v(0,1,1,0,0, 9,5, 0,1,0,0,S_R);
      add_v(1,1,0,0,0, 9,5, 1,1,0,0,S_R);
      add_v(1,1,0,0,0, 9,5, 2,1,0,0,S_R);
      add_v(1,1,0,0,0, 9,5, 3,1,0,0,S_R);
      for (int j = 0; j < 5; j++) add_v(1,0,0,0,0, 9,5, 3,1,0,0,S_R);
      add_v(1,1,0,0,0, 9,5, 4,1,0,0,S_R);
      add_v(1,1,0,0,0, 9,5, 5,0,0,1,S_R);
      add_v(0,0,1,0,0, 9,5, 0,1,0,0,S_R);
      add_v(1,0,0,0,0, 9,5, 0,1,0,0,S_R);
      add_v(0,0,0,1,0, 9,5, 0,0,0,0,S_I);
   endtask

   initial begin
      // reset
      rst_ni = 1'b0;
      drive_idle();
      oneshot_i = 1'b0; reload_i = '0; compare_i = '0;
      repeat (3) @(posedge clk_i);
      #1 check_all("reset", 0, 0, 0, 0, S_I);
      @(negedge clk_i) rst_ni = 1'b1;

      // vector table
      fill_table();
      for (int i = 0; i < vec_q.size(); i++) begin
         @(negedge clk_i);
         tick_i = vec_q[i].tick; en_i = vec_q[i].en;
         start_i = vec_q[i].start; stop_i = vec_q[i].stop;
         oneshot_i = vec_q[i].oneshot;
         reload_i = vec_q[i].reload; compare_i = vec_q[i].compare;
         @(posedge clk_i);
         #1 check_all($sformatf("vec%0d", i), vec_q[i].e_count, vec_q[i].e_pwm,
                      vec_q[i].e_ovf, vec_q[i].e_cmp, vec_q[i].e_st);
      end

      // async reset mid-count: reload=FFFF, count reaches 7
      @(negedge clk_i);
      drive_idle(); oneshot_i = 1'b0; reload_i = 16'hFFFF; compare_i = 16'h0010;
      start_i = 1'b1;
      @(negedge clk_i) start_i = 1'b0; tick_i = 1'b1;
      repeat (7) @(posedge clk_i);
      #1 check("arst.pre_count", 32'(count_o), 32'd7);
      @(negedge clk_i) tick_i = 1'b0;
      #1 rst_ni = 1'b0;
      #1 check_all("arst.now", 0, 0, 0, 0, S_I);
      @(negedge clk_i) rst_ni = 1'b1; tick_i = 1'b1;
      for (int j = 0; j < 3; j++) begin
         @(posedge clk_i);
         #1 check_all($sformatf("arst.post%0d", j), 0, 0, 0, 0, S_I);
      end

      // natural wrap at all-ones, tick held high (undivided)
      @(negedge clk_i);
      tick_i = 1'b0; reload_i = 16'hFFFF; compare_i = 16'h0000; start_i = 1'b1;
      @(negedge clk_i) start_i = 1'b0; tick_i = 1'b1;
      repeat (65535) @(posedge clk_i);
      #1 check_all("wrap.top", 16'hFFFF, 0, 0, 0, S_R);
      @(posedge clk_i);
      #1 check_all("wrap.zero", 16'h0000, 0, 1, 1, S_R);
      @(negedge clk_i) tick_i = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_timer_cmp_pwm

// File: doc/timer_cmp_pwm.md
Name: timer_cmp_pwm

Overview:
- Counter/compare stage directly downstream of the prescaled timer tick source.
- Consumes a one-cycle prescaler tick and runs an up-counter with auto-reload.
- Produces overflow and compare event pulses plus a PWM output.
- Runs entirely in the clk_i domain, with tick_i as a clock enable and no derived clocks.

Parameters:
WIDTH, 16, counter/reload/compare width in bits (legal 2..32)

Ports:
clk_i  input  1  system clock
rst_ni  input  1  asynchronous active-low reset
tick_i  input  1  prescaled tick, one clk_i cycle wide; advances counter when high
en_i  input  1  global enable; low freezes counter and state, ticks ignored
start_i  input  1  pulse: (re)start counting from 0
stop_i  input  1  pulse: abort to IDLE
oneshot_i  input  1  1 = stop after first overflow, 0 = periodic
reload_i  input  WIDTH  period minus one (top value)
compare_i  input  WIDTH  PWM duty / compare threshold
count_o  output  WIDTH  current counter value
pwm_o  output  1  high while count_o < active compare
ovf_o  output  1  one-cycle pulse on wrap top->0
cmp_o  output  1  one-cycle pulse when counter becomes equal to active compare
running_o  output  1  high in RUN

Behaviour:
- Clock and reset: one clock (clk_i). Reset is asynchronous and active-low (rst_ni). All state and outputs are registered.
- Reset values: state=IDLE, count_o=0, pwm_o=0, ovf_o=0, cmp_o=0, running_o=0, shadows=0.
- Reset asserted mid-count clears everything immediately. No event pulse is emitted on release.
- Shadow registers reload_sh and cmp_sh are loaded from reload_i/compare_i on start and on every wrap only. Input changes mid-period have no effect until the next wrap. This gives glitch-free PWM.
- FSM states:
  - IDLE: count held at 0, pwm_o=0. start_i -> RUN, count=0, shadows loaded.
  - RUN: on each cycle with tick_i & en_i:
    - if count==reload_sh: count<=0, ovf_o<=1, shadows reloaded; if oneshot_i -> DONE.
    - else count<=count+1.
  - DONE: count held at 0, pwm_o=0, running_o=0. start_i -> RUN as from IDLE.
- stop_i in any state -> IDLE, count=0, no pulses.
- Priority: rst_ni > stop_i > start_i > tick.
- start_i while in RUN restarts: count=0, shadows reloaded, no ovf_o pulse.
- Event latency: ovf_o and cmp_o are high in the same cycle that count_o shows the new value, i.e. one clk_i after the tick was sampled. Both are low in all other cycles.
- cmp_o: asserted when the value being written to count equals cmp_sh, including 0 after a wrap when cmp_sh==0. ovf_o and cmp_o may assert together.
- pwm_o: registered, equals (next count < next cmp_sh) in RUN.
  - cmp_sh=0 -> constant 0.
  - cmp_sh>reload_sh -> constant 1.
- Duty = cmp_sh/(reload_sh+1) periods of ticks.
- reload_sh=0: count stays 0 and ovf_o pulses on every qualified tick.
- Arithmetic: unsigned, WIDTH bits. reload=2^WIDTH-1 wraps naturally at all-ones, with no extra bit.
- en_i low: ticks dropped (not queued), state/count/shadows held. start_i and stop_i are still honoured.
- tick_i held high continuously is legal: count advances every clk_i (undivided case).

Decomposition:
- Shared package timer_pkg: FSM state typedef (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and default WIDTH constant.
- No sub-module required. Shadow registers and compare logic stay inline.

Test Plan:
- Periodic PWM: reload=4, compare=2, tick_i every cycle, start -> count 0,1,2,3,4,0; pwm_o 1,1,0,0,0,1; ovf_o on each return to 0; cmp_o when count==2.
- Shadow update: running reload=9, compare=3; change compare to 7 at count=5 -> pwm edge stays at 3 this period, at 7 from the next period (after ovf_o).
- One-shot: oneshot=1, reload=3, tick every 4th cycle -> count 0..3, ovf_o once, then DONE, running_o=0, count_o=0. Further ticks produce no pulses; a new start runs again.
- Boundaries: compare=0 -> pwm_o always 0 and cmp_o at each wrap; compare=reload+1 -> pwm_o always 1 and no cmp_o; reload=0 -> ovf_o every tick.
- Control priority: assert start_i and stop_i together in RUN -> IDLE. Drop en_i for 5 ticks -> count frozen. Restore en_i -> resumes from the held value.
- Async reset mid-count (count=7, WIDTH=16, reload=0xFFFF) -> all outputs 0 immediately. After release, idle until start_i.
